// File: rtl/vector_slice_elastic.sv
// vector_slice_elastic: one VLEN-bit vector lane with a small vreg file, a
// split-carry ALU, neighbour rotate inputs and elastic scratchpad side channels.
// An instruction is held on t_instr_* until every side channel it needs has
// handshaken exactly once. The result is registered and written back on the
// following edge, and a bypass path covers back-to-back dependencies.
module vector_slice_elastic #(
    parameter int VLEN       = 16,
    parameter int NREGS      = 16,
    parameter int SPLIT      = 12,
    parameter int PREDICATOR = 0,
    parameter int OPWIDTH    = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPWIDTH-1:0]  t_instr_data,
    input  logic                t_instr_valid,
    output logic                t_instr_ready,
    input  logic [VLEN-1:0]     l_data,
    input  logic [VLEN-1:0]     r_data,
    output logic [VLEN-1:0]     o_data,
    output logic [VLEN-1:0]     i0_data,
    output logic [3:0]          i0_k,
    output logic                i0_valid,
    input  logic                i0_ready,
    output logic [2*VLEN-1:0]   i_k_data,
    output logic                i_k_valid,
    input  logic                i_k_ready,
    input  logic [2*VLEN-1:0]   t_k_data,
    input  logic                t_k_valid,
    output logic                t_k_ready
);

    localparam logic [3:0] F_NOP  = 4'h0;
    localparam logic [3:0] F_ADD  = 4'h1;
    localparam logic [3:0] F_SUB  = 4'h2;
    localparam logic [3:0] F_AND  = 4'h3;
    localparam logic [3:0] F_OR   = 4'h4;
    localparam logic [3:0] F_XOR  = 4'h5;
    localparam logic [3:0] F_MV   = 4'h6;
    localparam logic [3:0] F_ROL  = 4'h8;
    localparam logic [3:0] F_ROR  = 4'h9;
    localparam logic [3:0] F_MVXV = 4'hA;
    localparam logic [3:0] F_MVKV = 4'hB;
    localparam logic [3:0] F_MVVK = 4'hF;

    // Carry break: the low segment is [SPL-1:0]; SPL=VLEN means a single segment.
    localparam int              SPL     = (SPLIT > VLEN) ? VLEN : SPLIT;
    localparam logic [VLEN-1:0] LO_MASK = {VLEN{1'b1}} >> (VLEN - SPL);
    localparam logic [VLEN-1:0] HI_MASK = ~LO_MASK;
    localparam logic [4:0]      NREGS_W = 5'(NREGS);

    // Architectural and pipeline state
    logic [VLEN-1:0] r_vreg [16];
    logic [VLEN-1:0] r_wb_data;
    logic [3:0]      r_wb_dest;
    logic            r_wb_we;
    logic            r_i0_done;
    logic            r_ik_done;
    logic            r_tk_done;
    logic [VLEN-1:0] r_hold;
    logic            r_live;

    // Instruction fields
    logic [31:0]      w_xrs;
    logic [3:0]       w_src1;
    logic [3:0]       w_ks;
    logic [3:0]       w_src2;
    logic [3:0]       w_funct;
    logic [3:0]       w_dest;
    logic [VLEN+31:0] w_xrs_ext;
    logic [VLEN-1:0]  w_xrs_v;

    assign w_xrs     = t_instr_data[63:32];
    assign w_src1    = t_instr_data[31:28];
    assign w_ks      = t_instr_data[27:24];
    assign w_src2    = t_instr_data[23:20];
    assign w_funct   = t_instr_data[14:11];
    assign w_dest    = t_instr_data[10:7];
    assign w_xrs_ext = {{VLEN{1'b0}}, w_xrs};
    assign w_xrs_v   = w_xrs_ext[VLEN-1:0];

    // Fields and bits this lane never looks at.
    logic w_unused;
    assign w_unused = ^{t_instr_data[19:15], t_instr_data[6:0],
                        t_k_data[2*VLEN-1:VLEN], w_xrs_ext[VLEN+31:VLEN]};

    logic w_src1_ok;
    logic w_src2_ok;
    logic w_dest_ok;
    assign w_src1_ok = ({1'b0, w_src1} < NREGS_W);
    assign w_src2_ok = ({1'b0, w_src2} < NREGS_W);
    assign w_dest_ok = ({1'b0, w_dest} < NREGS_W);

    // Operand reads with forwarding from the pending write-back
    logic [VLEN-1:0] w_a;
    logic [VLEN-1:0] w_b;
    always_comb begin
        w_a = {VLEN{1'b0}};
        w_b = {VLEN{1'b0}};
        if (r_wb_we && (w_src1 == r_wb_dest)) begin
            w_a = r_wb_data;
        end else if (w_src1_ok) begin
            w_a = r_vreg[w_src1];
        end else begin
            w_a = {VLEN{1'b0}};
        end
        if (r_wb_we && (w_src2 == r_wb_dest)) begin
            w_b = r_wb_data;
        end else if (w_src2_ok) begin
            w_b = r_vreg[w_src2];
        end else begin
            w_b = {VLEN{1'b0}};
        end
    end

    assign o_data   = w_b;
    assign i0_data  = w_a;
    assign i0_k     = w_ks;
    assign i_k_data = {{VLEN{1'b0}}, w_b};

    // Side-channel requirements and handshakes
    logic w_need_i0;
    logic w_need_ik;
    logic w_need_tk;
    logic w_live_valid;
    logic w_i0_hs;
    logic w_ik_hs;
    logic w_tk_hs;
    logic w_all_ok;
    logic w_accept;

    assign w_need_i0    = (w_ks != 4'h0);
    assign w_need_ik    = (w_funct == F_MVVK);
    assign w_need_tk    = (w_funct == F_MVKV);
    // r_live keeps every request low while reset is asserted, whatever the master drives.
    assign w_live_valid = t_instr_valid & r_live;

    assign i0_valid  = w_live_valid & w_need_i0 & ~r_i0_done;
    assign i_k_valid = w_live_valid & w_need_ik & ~r_ik_done;
    assign t_k_ready = w_live_valid & w_need_tk & ~r_tk_done;

    assign w_i0_hs = i0_valid & i0_ready;
    assign w_ik_hs = i_k_valid & i_k_ready;
    assign w_tk_hs = t_k_ready & t_k_valid;

    assign w_all_ok = (~w_need_i0 | r_i0_done | w_i0_hs) &
                      (~w_need_ik | r_ik_done | w_ik_hs) &
                      (~w_need_tk | r_tk_done | w_tk_hs);

    assign t_instr_ready = ~t_instr_valid | (r_live & w_all_ok);
    assign w_accept      = w_live_valid & w_all_ok;

    // K value: take it straight from the bus if it arrives in the accept cycle.
    logic [VLEN-1:0] w_k_val;
    assign w_k_val = w_tk_hs ? t_k_data[VLEN-1:0] : r_hold;

    // Split-segment add/subtract: no carry or borrow crosses the SPLIT boundary
    logic [VLEN-1:0] w_add;
    logic [VLEN-1:0] w_sub;
    assign w_add = (((w_a & LO_MASK) + (w_b & LO_MASK)) & LO_MASK) |
                   (((w_a & HI_MASK) + (w_b & HI_MASK)) & HI_MASK);
    assign w_sub = (((w_a & LO_MASK) - (w_b & LO_MASK)) & LO_MASK) |
                   (((w_a & HI_MASK) - (w_b & HI_MASK)) & HI_MASK);

    // Result select and whether this funct writes a vector register
    logic [VLEN-1:0] w_result;
    logic            w_writes;
    always_comb begin
        w_result = {VLEN{1'b0}};
        w_writes = 1'b0;
        case (w_funct)
            F_ADD:   begin w_result = w_add;       w_writes = 1'b1; end
            F_SUB:   begin w_result = w_sub;       w_writes = 1'b1; end
            F_AND:   begin w_result = w_a & w_b;   w_writes = 1'b1; end
            F_OR:    begin w_result = w_a | w_b;   w_writes = 1'b1; end
            F_XOR:   begin w_result = w_a ^ w_b;   w_writes = 1'b1; end
            F_MV:    begin w_result = w_b;         w_writes = 1'b1; end
            F_ROL:   begin w_result = l_data;      w_writes = 1'b1; end
            F_ROR:   begin w_result = r_data;      w_writes = 1'b1; end
            F_MVXV:  begin w_result = w_xrs_v;     w_writes = 1'b1; end
            F_MVKV:  begin w_result = w_k_val;     w_writes = 1'b1; end
            F_NOP:   begin w_result = {VLEN{1'b0}}; w_writes = 1'b0; end
            default: begin w_result = {VLEN{1'b0}}; w_writes = 1'b0; end
        endcase
    end

    // The predicate bit disables the write for everything except MV_X_V.
    logic w_pred_ok;
    logic w_we;
    assign w_pred_ok = ~w_xrs[PREDICATOR] | (w_funct == F_MVXV);
    assign w_we      = w_accept & w_pred_ok & w_writes & w_dest_ok;

    // Live flag: low while in reset, high from the first clock after release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Per-instruction done flags, cleared on acceptance or when valid drops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i0_done <= 1'b0;
            r_ik_done <= 1'b0;
            r_tk_done <= 1'b0;
        end else if (!t_instr_valid || w_accept) begin
            r_i0_done <= 1'b0;
            r_ik_done <= 1'b0;
            r_tk_done <= 1'b0;
        end else begin
            r_i0_done <= r_i0_done | w_i0_hs;
            r_ik_done <= r_ik_done | w_ik_hs;
            r_tk_done <= r_tk_done | w_tk_hs;
        end
    end

    // Capture returned K data on its handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold <= {VLEN{1'b0}};
        end else if (w_tk_hs) begin
            r_hold <= t_k_data[VLEN-1:0];
        end
    end

    // Write-back register, loaded at acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wb_we   <= 1'b0;
            r_wb_data <= {VLEN{1'b0}};
            r_wb_dest <= 4'h0;
        end else begin
            r_wb_we <= w_we;
            if (w_we) begin
                r_wb_data <= w_result;
                r_wb_dest <= w_dest;
            end
        end
    end

    // Vector register file update from the write-back register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                r_vreg[i] <= {VLEN{1'b0}};
            end
        end else if (r_wb_we) begin
            r_vreg[r_wb_dest] <= r_wb_data;
        end
    end

endmodule

// File: tb/tb_vector_slice_elastic.sv
// Directed bench for vector_slice_elastic (VLEN=16, SPLIT=12, NREGS=16).
module tb_vector_slice_elastic;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] t_instr_data;
    logic        t_instr_valid;
    logic        t_instr_ready;
    logic [15:0] l_data;
    logic [15:0] r_data;
    logic [15:0] o_data;
    logic [15:0] i0_data;
    logic [3:0]  i0_k;
    logic        i0_valid;
    logic        i0_ready;
    logic [31:0] i_k_data;
    logic        i_k_valid;
    logic        i_k_ready;
    logic [31:0] t_k_data;
    logic        t_k_valid;
    logic        t_k_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_i0   = 0;
    int cnt_ik   = 0;
    int cnt_tk   = 0;
    int c0, c1, c2;

    vector_slice_elastic dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .t_instr_data  (t_instr_data),
        .t_instr_valid (t_instr_valid),
        .t_instr_ready (t_instr_ready),
        .l_data        (l_data),
        .r_data        (r_data),
        .o_data        (o_data),
        .i0_data       (i0_data),
        .i0_k          (i0_k),
        .i0_valid      (i0_valid),
        .i0_ready      (i0_ready),
        .i_k_data      (i_k_data),
        .i_k_valid     (i_k_valid),
        .i_k_ready     (i_k_ready),
        .t_k_data      (t_k_data),
        .t_k_valid     (t_k_valid),
        .t_k_ready     (t_k_ready)
    );

    always #5 clk = ~clk;

    // Side-channel handshake counters
    always @(posedge clk) begin
        if (i0_valid && i0_ready)  cnt_i0 <= cnt_i0 + 1;
        if (i_k_valid && i_k_ready) cnt_ik <= cnt_ik + 1;
        if (t_k_valid && t_k_ready) cnt_tk <= cnt_tk + 1;
    end

    function automatic logic [63:0] mk(input logic [31:0] xrs, input logic [3:0] s1,
                                       input logic [3:0] ks, input logic [3:0] s2,
                                       input logic [3:0] fn, input logic [3:0] dst);
        logic [63:0] v;
        v        = 64'h0;
        v[63:32] = xrs;
        v[31:28] = s1;
        v[27:24] = ks;
        v[23:20] = s2;
        v[14:11] = fn;
        v[10:7]  = dst;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue an instruction with no side-channel stall
    task automatic issue(input string tag, input logic [63:0] ins);
        t_instr_data  = ins;
        t_instr_valid = 1'b1;
        #1;
        chk(tag, {31'h0, t_instr_ready}, 32'h1);
        tick();
        t_instr_valid = 1'b0;
    endtask

    // Read a vreg through the src2 port (o_data)
    task automatic rd(input string tag, input logic [3:0] idx, input logic [15:0] exp);
        t_instr_valid = 1'b0;
        t_instr_data  = mk(32'h0, 4'h0, 4'h0, idx, 4'h0, 4'h0);
        #1;
        chk(tag, {16'h0, o_data}, {16'h0, exp});
    endtask

    initial begin
        reset_n       = 1'b0;
        t_instr_valid = 1'b0;
        t_instr_data  = 64'h0;
        l_data        = 16'h0;
        r_data        = 16'h0;
        i0_ready      = 1'b1;
        i_k_ready     = 1'b1;
        t_k_valid     = 1'b0;
        t_k_data      = 32'h0;
        #2;
        chk("rst_i0_valid", {31'h0, i0_valid}, 32'h0);
        chk("rst_ik_valid", {31'h0, i_k_valid}, 32'h0);
        chk("rst_tk_ready", {31'h0, t_k_ready}, 32'h0);
        chk("rst_o_data", {16'h0, o_data}, 32'h0);
        chk("rst_i0_data", {16'h0, i0_data}, 32'h0);
        chk("rst_ik_data", i_k_data, 32'h0);
        chk("rst_instr_ready", {31'h0, t_instr_ready}, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // T1: split-carry ADD/SUB
        issue("t1_mvx1", mk(32'h0000_0FFF, 4'h0, 4'h0, 4'h0, 4'hA, 4'h1));
        issue("t1_mvx2", mk(32'h0000_F001, 4'h0, 4'h0, 4'h0, 4'hA, 4'h2));
        issue("t1_add",  mk(32'h0, 4'h1, 4'h0, 4'h2, 4'h1, 4'h3));
        issue("t1_sub",  mk(32'h0, 4'h2, 4'h0, 4'h1, 4'h2, 4'h4));
        rd("t1_v4", 4'h4, 16'hF002);
        tick();
        rd("t1_v1", 4'h1, 16'h0FFF);
        rd("t1_v2", 4'h2, 16'hF001);
        rd("t1_v3", 4'h3, 16'hF000);
        rd("t1_v4_rf", 4'h4, 16'hF002);

        // Bitwise ops on v1=0x0FFF, v2=0xF001
        issue("t1_and", mk(32'h0, 4'h1, 4'h0, 4'h2, 4'h3, 4'hC));
        issue("t1_or",  mk(32'h0, 4'h1, 4'h0, 4'h2, 4'h4, 4'hD));
        issue("t1_xor", mk(32'h0, 4'h1, 4'h0, 4'h2, 4'h5, 4'hE));
        tick();
        rd("t1_vC", 4'hC, 16'h0001);
        rd("t1_vD", 4'hD, 16'hFFFF);
        rd("t1_vE", 4'hE, 16'hFFFE);

        // T2: back-to-back dependency through the bypass
        issue("t2_mvx1", mk(32'h0000_1234, 4'h0, 4'h0, 4'h0, 4'hA, 4'h1));
        t_instr_data  = mk(32'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h2);
        t_instr_valid = 1'b1;
        #1;
        chk("t2_byp_src1", {16'h0, i0_data}, 32'h1234);
        chk("t2_byp_src2", {16'h0, o_data}, 32'h1234);
        tick();
        t_instr_valid = 1'b0;
        tick();
        rd("t2_v2", 4'h2, 16'h2468);

        // Neighbour moves; inputs sampled at acceptance only
        l_data = 16'hBEEF;
        r_data = 16'h5A5A;
        issue("t2_rol", mk(32'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h7));
        issue("t2_ror", mk(32'h0, 4'h0, 4'h0, 4'h0, 4'h9, 4'h8));
        l_data = 16'h0000;
        r_data = 16'h0000;
        issue("t2_nop", mk(32'h0000_FFFF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7));
        issue("t2_undef", mk(32'h0, 4'h0, 4'h0, 4'h1, 4'h7, 4'h8));
        tick();
        rd("t2_v7", 4'h7, 16'hBEEF);
        rd("t2_v8", 4'h8, 16'h5A5A);

        // T3: scratch request stalled 4 cycles
        c0 = cnt_i0;
        i0_ready      = 1'b0;
        t_instr_data  = mk(32'h0, 4'h2, 4'h3, 4'h1, 4'h6, 4'h9);
        t_instr_valid = 1'b1;
        #1;
        chk("t3_i0_data", {16'h0, i0_data}, 32'h2468);
        chk("t3_i0_k", {28'h0, i0_k}, 32'h3);
        for (int i = 0; i < 4; i++) begin
            chk("t3_stall_ready", {31'h0, t_instr_ready}, 32'h0);
            chk("t3_stall_i0v", {31'h0, i0_valid}, 32'h1);
            tick();
        end
        i0_ready = 1'b1;
        #1;
        chk("t3_ready", {31'h0, t_instr_ready}, 32'h1);
        tick();
        t_instr_valid = 1'b0;
        chk("t3_i0_count", 32'(cnt_i0 - c0), 32'h1);
        tick();
        rd("t3_v9", 4'h9, 16'h1234);

        // T4: K return delayed 3 cycles
        c2 = cnt_tk;
        t_instr_data  = mk(32'h0, 4'h0, 4'h0, 4'h0, 4'hB, 4'h5);
        t_instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_tk_ready", {31'h0, t_k_ready}, 32'h1);
            chk("t4_stall_ready", {31'h0, t_instr_ready}, 32'h0);
            tick();
        end
        t_k_valid = 1'b1;
        t_k_data  = 32'h0000_00AB;
        #1;
        chk("t4_ready", {31'h0, t_instr_ready}, 32'h1);
        tick();
        t_k_valid     = 1'b0;
        t_k_data      = 32'hDEAD_DEAD;
        t_instr_valid = 1'b0;
        chk("t4_tk_count", 32'(cnt_tk - c2), 32'h1);
        rd("t4_v5_byp", 4'h5, 16'h00AB);
        tick();
        rd("t4_v5", 4'h5, 16'h00AB);

        // K data arriving before the scratch handshake comes from the hold register
        c0 = cnt_i0;
        c2 = cnt_tk;
        i0_ready      = 1'b0;
        t_k_valid     = 1'b1;
        t_k_data      = 32'h0000_1357;
        t_instr_data  = mk(32'h0, 4'h0, 4'h1, 4'h0, 4'hB, 4'hA);
        t_instr_valid = 1'b1;
        tick();
        t_k_data = 32'hFFFF_FFFF;
        #1;
        chk("hold_tk_done", {31'h0, t_k_ready}, 32'h0);
        chk("hold_stall", {31'h0, t_instr_ready}, 32'h0);
        tick();
        i0_ready = 1'b1;
        tick();
        t_instr_valid = 1'b0;
        t_k_valid     = 1'b0;
        chk("hold_tk_count", 32'(cnt_tk - c2), 32'h1);
        chk("hold_i0_count", 32'(cnt_i0 - c0), 32'h1);
        tick();
        rd("hold_vA", 4'hA, 16'h1357);

        // T5: predicate suppression and both side channels in one instruction
        issue("t5_add_pred", mk(32'h0000_0001, 4'h1, 4'h0, 4'h1, 4'h1, 4'h6));
        tick();
        rd("t5_v6_pred", 4'h6, 16'h0000);
        issue("t5_mvx_pred", mk(32'h0000_0001, 4'h0, 4'h0, 4'h0, 4'hA, 4'h6));
        c0 = cnt_i0;
        c1 = cnt_ik;
        i0_ready      = 1'b0;
        t_instr_data  = mk(32'h0000_0001, 4'h0, 4'h2, 4'h6, 4'hF, 4'h6);
        t_instr_valid = 1'b1;
        #1;
        chk("t5_ik_data", i_k_data, 32'h0000_0001);
        chk("t5_ik_valid", {31'h0, i_k_valid}, 32'h1);
        chk("t5_i0_valid", {31'h0, i0_valid}, 32'h1);
        chk("t5_stall", {31'h0, t_instr_ready}, 32'h0);
        tick();
        chk("t5_ik_done", {31'h0, i_k_valid}, 32'h0);
        chk("t5_stall2", {31'h0, t_instr_ready}, 32'h0);
        i0_ready = 1'b1;
        #1;
        chk("t5_ready", {31'h0, t_instr_ready}, 32'h1);
        tick();
        t_instr_valid = 1'b0;
        chk("t5_ik_count", 32'(cnt_ik - c1), 32'h1);
        chk("t5_i0_count", 32'(cnt_i0 - c0), 32'h1);
        tick();
        rd("t5_v6", 4'h6, 16'h0001);

        // T6: reset during a scratch stall
        c0 = cnt_i0;
        i0_ready      = 1'b0;
        t_instr_data  = mk(32'h0000_00C0, 4'h0, 4'h3, 4'h0, 4'hA, 4'hB);
        t_instr_valid = 1'b1;
        tick();
        tick();
        chk("t6_i0v_pre", {31'h0, i0_valid}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("t6_i0v_rst", {31'h0, i0_valid}, 32'h0);
        t_instr_valid = 1'b0;
        i0_ready      = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("t6_ready_idle", {31'h0, t_instr_ready}, 32'h1);
        rd("t6_vB", 4'hB, 16'h0000);
        rd("t6_v1", 4'h1, 16'h0000);
        chk("t6_i0_count", 32'(cnt_i0 - c0), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
